// File: rtl/mac_result_buf.sv
// mac_result_buf: buffers MAC dot-product results in a small FIFO and streams them
// out on valid/ready, tagging the last row of each product. Option: RESULT_SAT_EN.
module mac_result_buf #(
    parameter int DEPTH    = 4,
    parameter int NUM_ROWS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                f,
    input  logic                       valid_in,
    input  logic                       ovf_in,
    output logic [15:0]                out_data,
    output logic                       out_ovf,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

    // entry = {last, ovf, data}
    logic [17:0]   mem [DEPTH];
    logic [17:0]   head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [RW-1:0] row_cnt;
    logic [15:0]   wdata;
    logic          pop;
    logic          push;
    logic          is_last;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = valid_in & ((count != FULL) | pop);
    assign is_last   = (row_cnt == LAST_ROW);

    always_comb begin
        wdata = f;
`ifdef RESULT_SAT_EN
        if (ovf_in) wdata = f[15] ? 16'h7FFF : 16'h8000;
`endif
    end

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[15:0] : 16'h0000;
    assign out_ovf  = out_valid & head[16];
    assign out_last = out_valid & head[17];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            row_cnt  <= '0;
            drop_err <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // Rows advance even on a dropped result to keep last-tag aligned with the MAC.
            if (valid_in) row_cnt <= is_last ? '0 : row_cnt + 1'b1;
            if (valid_in && !push) drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {is_last, ovf_in, wdata};
    end

endmodule

// File: tb/tb_mac_result_buf.sv
// tb_mac_result_buf: directed and random stimulus for mac_result_buf, checked against
// a queue-based model of the result stream.
module tb_mac_result_buf;

    localparam int DEPTH    = 4;
    localparam int NUM_ROWS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] f = '0;
    logic        valid_in = 1'b0;
    logic        ovf_in = 1'b0;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic        drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] model_q[$];
    int          model_row = 0;
    bit          model_drop = 0;

    mac_result_buf #(.DEPTH(DEPTH), .NUM_ROWS(NUM_ROWS)) dut (
        .clk(clk), .reset(reset), .f(f), .valid_in(valid_in), .ovf_in(ovf_in),
        .out_data(out_data), .out_ovf(out_ovf), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] stored_value(input logic [15:0] v, input logic o);
`ifdef RESULT_SAT_EN
        if (o) return v[15] ? 16'h7FFF : 16'h8000;
`endif
        return v;
    endfunction

    // Checks outputs mid-cycle, then advances the model across the next rising edge.
    task automatic step();
        bit pop, push;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("count", 32'(count), 32'(model_q.size()));
        check("drop_err", 32'(drop_err), 32'(model_drop));
        if (model_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(model_q[0][15:0]));
            check("out_ovf", 32'(out_ovf), 32'(model_q[0][16]));
            check("out_last", 32'(out_last), 32'(model_q[0][17]));
        end
        pop  = (model_q.size() != 0) && out_ready;
        push = valid_in && ((model_q.size() < DEPTH) || pop);
        @(posedge clk);
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back({(model_row == NUM_ROWS - 1), ovf_in, stored_value(f, ovf_in)});
        if (valid_in && !push) model_drop = 1;
        if (valid_in) model_row = (model_row + 1) % NUM_ROWS;
        #1;
    endtask

    task automatic do_reset();
        valid_in = 0; out_ready = 0;
        #2 reset = 0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_drop", 32'(drop_err), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        model_q.delete(); model_row = 0; model_drop = 0;
        @(posedge clk); #1;
        reset = 1;
    endtask

    task automatic push_one(input logic [15:0] v, input logic o);
        f = v; ovf_in = o; valid_in = 1;
        step();
        valid_in = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        check("rst_ovf", 32'(out_ovf), 32'd0);

        // single result, one-cycle latency
        out_ready = 1;
        push_one(16'h0123, 0);
        step(); step();

        // row tagging: 16 spaced pushes
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            push_one(16'(i + 16'h100), 0);
            step();
        end
        step();

        // backpressure and drop
        do_reset();
        out_ready = 0;
        for (int i = 1; i <= 5; i++) push_one(16'(i), 0);
        step();
        check("bp_count", 32'(count), 32'd4);
        check("bp_drop", 32'(drop_err), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 6; i++) step();
        check("bp_drop_sticky", 32'(drop_err), 32'd1);

        // full with simultaneous pop
        do_reset();
        out_ready = 0;
        for (int i = 1; i <= 4; i++) push_one(16'(i + 16'h20), 0);
        out_ready = 1;
        push_one(16'd9, 0);
        check("fp_count", 32'(count), 32'd4);
        check("fp_drop", 32'(drop_err), 32'd0);
        for (int i = 0; i < 6; i++) step();

        // overflow tagging / saturation
        do_reset();
        out_ready = 1;
        push_one(16'h8005, 1);
        step();
        push_one(16'h7FF0, 1);
        step();
        push_one(16'h1234, 0);
        step(); step();

        // asynchronous reset mid-stream, then row count restarts
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 3; i++) push_one(16'(i + 16'h40), 0);
        for (int i = 0; i < 2; i++) push_one(16'(i + 16'h50), 0);
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            push_one(16'(i + 16'h60), 0);
            step();
        end

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            valid_in  = ($urandom_range(0, 1) == 1);
            f         = 16'($urandom);
            ovf_in    = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (i > 1500 && i < 1700) out_ready = ($urandom_range(0, 7) == 0);
            step();
        end
        valid_in = 0; out_ready = 1;
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
